// File: rtl/count_capture_pkg.sv
// ------------------------------------------------------------------
// count_capture_pkg: shared constants for count_capture.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package count_capture_pkg;

  localparam int c_default_stable_cycles = 3;

  // Segment order: seg[6:0] = {g,f,e,d,c,b,a}, active high.
  localparam int c_seg_a = 0;
  localparam int c_seg_b = 1;
  localparam int c_seg_c = 2;
  localparam int c_seg_d = 3;
  localparam int c_seg_e = 4;
  localparam int c_seg_f = 5;
  localparam int c_seg_g = 6;

  typedef logic [6:0] seg7_t;

  localparam seg7_t c_seg7_0 = 7'h3F;
  localparam seg7_t c_seg7_1 = 7'h06;
  localparam seg7_t c_seg7_2 = 7'h5B;
  localparam seg7_t c_seg7_3 = 7'h4F;
  localparam seg7_t c_seg7_4 = 7'h66;
  localparam seg7_t c_seg7_5 = 7'h6D;
  localparam seg7_t c_seg7_6 = 7'h7D;
  localparam seg7_t c_seg7_7 = 7'h07;
  localparam seg7_t c_seg7_8 = 7'h7F;
  localparam seg7_t c_seg7_9 = 7'h6F;
  localparam seg7_t c_seg7_a = 7'h77;
  localparam seg7_t c_seg7_b = 7'h7C;
  localparam seg7_t c_seg7_c = 7'h39;
  localparam seg7_t c_seg7_d = 7'h5E;
  localparam seg7_t c_seg7_e = 7'h79;
  localparam seg7_t c_seg7_f = 7'h71;

  localparam seg7_t c_seg7_table [16] = '{
    c_seg7_0, c_seg7_1, c_seg7_2, c_seg7_3,
    c_seg7_4, c_seg7_5, c_seg7_6, c_seg7_7,
    c_seg7_8, c_seg7_9, c_seg7_a, c_seg7_b,
    c_seg7_c, c_seg7_d, c_seg7_e, c_seg7_f
  };

endpackage

`default_nettype wire

// File: rtl/seg7_decoder.sv
// ------------------------------------------------------------------
// seg7_decoder: combinational hex to gfedcba 7-segment decode.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module seg7_decoder
  import count_capture_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = c_seg7_table[i_hex];

endmodule

`default_nettype wire

// File: rtl/count_capture.sv
// ------------------------------------------------------------------
// count_capture: synchronize and debounce a 4-bit ripple count, flag wraps.
// Optional seg output when COUNT_CAPTURE_SEG7_EN is defined.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module count_capture
  import count_capture_pkg::*;
#(
  parameter int STABLE_CYCLES = c_default_stable_cycles
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cnt_in,
  output logic [3:0] value,
  output logic       upd,
  output logic       wrap,
  output logic [7:0] wrap_count
`ifdef COUNT_CAPTURE_SEG7_EN
  ,
  output logic [6:0] seg
`endif
);

  localparam logic [3:0] c_stab_max = 4'(STABLE_CYCLES);

  logic [3:0] r_s1;
  logic [3:0] r_s2;
  logic [3:0] r_cand;
  logic [3:0] r_stab;
  logic [3:0] r_value;
  logic       r_upd;
  logic       r_wrap;
  logic [7:0] r_wrap_count;
  logic       w_accept;
  logic       w_change;

  // Acceptance fires on the edge where stab would step to STABLE_CYCLES.
  assign w_accept = (r_s2 == r_cand) && (r_stab == c_stab_max - 4'd1);
  assign w_change = w_accept && (r_cand != r_value);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1         <= 4'd0;
      r_s2         <= 4'd0;
      r_cand       <= 4'd0;
      r_stab       <= 4'd0;
      r_value      <= 4'd0;
      r_upd        <= 1'b0;
      r_wrap       <= 1'b0;
      r_wrap_count <= 8'd0;
    end else begin
      r_s1   <= cnt_in;
      r_s2   <= r_s1;
      r_upd  <= 1'b0;
      r_wrap <= 1'b0;
      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_stab <= 4'd0;
      end else if (r_stab < c_stab_max) begin
        r_stab <= r_stab + 4'd1;
      end
      if (w_change) begin
        r_value <= r_cand;
        r_upd   <= 1'b1;
        if ((r_value == 4'd15) && (r_cand == 4'd0)) begin
          r_wrap       <= 1'b1;
          r_wrap_count <= r_wrap_count + 8'd1;
        end
      end
    end
  end

  assign value      = r_value;
  assign upd        = r_upd;
  assign wrap       = r_wrap;
  assign wrap_count = r_wrap_count;

`ifdef COUNT_CAPTURE_SEG7_EN
  logic [6:0] w_seg;
  logic [6:0] r_seg;

  // Decode the candidate so the segment register loads alongside value.
  seg7_decoder u_seg7_decoder (
    .i_hex (r_cand),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= c_seg7_0;
    end else if (w_change) begin
      r_seg <= w_seg;
    end
  end

  assign seg = r_seg;
`endif

endmodule

`default_nettype wire

// File: doc/count_capture.md
COUNT_CAPTURE -- requirements
Module: count_capture

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 3, giving the consecutive equal synchronized samples required before a count is accepted; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port cnt_in, input, 4 bits: the ripple-counter value, asynchronous to clk.
REQ-005 The block SHALL have port value, output, 4 bits: the last accepted stable count.
REQ-006 The block SHALL have port upd, output, 1 bit: one-cycle pulse, high in the cycle value changes.
REQ-007 The block SHALL have port wrap, output, 1 bit: one-cycle pulse, high when value goes 15 -> 0.
REQ-008 The block SHALL have port wrap_count, output, 8 bits: number of accepted wraps, modulo 256.
REQ-009 The block SHALL have port seg, output, 7 bits: active-high gfedcba pattern of value in hex; present only when COUNT_CAPTURE_SEG7_EN is defined.

Function
REQ-010 The block SHALL pass cnt_in through a two-flop synchronizer (s1, s2) before any use.
REQ-011 The block SHALL keep a candidate register cand and a 4-bit stability counter stab.
REQ-012 When s2 != cand, the block SHALL load cand <= s2 and clear stab <= 0.
REQ-013 When s2 == cand and stab < STABLE_CYCLES, the block SHALL increment stab; when stab == STABLE_CYCLES, stab SHALL hold (saturate).
REQ-014 The block SHALL accept the candidate on the edge where stab goes STABLE_CYCLES-1 -> STABLE_CYCLES.
REQ-015 On acceptance with cand != value, the block SHALL register value <= cand and upd <= 1 for exactly one cycle.
REQ-016 On acceptance with cand == value, the block SHALL leave value unchanged and SHALL NOT pulse upd.
REQ-017 On acceptance where old value == 15 and cand == 0, the block SHALL pulse wrap together with upd and increment wrap_count; 255 rolls over to 0.
REQ-018 An acceptance from any other value to 0, or from 15 to a nonzero value, SHALL NOT pulse wrap.
REQ-019 Latency SHALL be STABLE_CYCLES+3 edges, counting the first edge that samples a new steady cnt_in as edge 1; with the default this is 6 edges.
REQ-020 Glitch states SHALL never reach value: any intermediate cnt_in state shorter than STABLE_CYCLES+1 synchronized samples is discarded, e.g. ripple 7 -> 6 -> 4 -> 0 -> 8.
REQ-021 If cnt_in changes while stab is counting, the block SHALL restart qualification on the newest s2 value with no output effect.
REQ-022 seg SHALL be a registered decode of value, updating in the same cycle as value.

Reset
REQ-023 While rst is high, the block SHALL asynchronously clear s1, s2, cand, stab, value, upd, wrap and wrap_count to 0, and set seg to 7'h3F.
REQ-024 After rst deasserts, the block SHALL resume from those states; a steady nonzero cnt_in is accepted after STABLE_CYCLES+3 edges with upd pulsed.
REQ-025 Reset asserted mid-qualification SHALL abandon the candidate with no upd or wrap pulse.

Configuration
REQ-026 With COUNT_CAPTURE_SEG7_EN defined, the block SHALL include port seg and instantiate the decoder.
REQ-027 Without COUNT_CAPTURE_SEG7_EN, the block SHALL omit seg and the decoder; all other behaviour SHALL be identical.

Structure
REQ-028 A shared package SHALL hold the seg7 pattern constants for 0-F, the segment-order definition, and the default STABLE_CYCLES.
REQ-029 The hex-to-7-segment decode SHALL be the sub-module seg7_decoder (4-bit in, 7-bit out, combinational); the output register SHALL be in count_capture.

Verification
REQ-030 Reset with cnt_in=5, then release and hold -> value=5, upd pulses once at edge 6, seg=7'h6D.
REQ-031 value=7, then cnt_in sequence 6, 4, 0 (one cycle each), then 8 held -> value jumps directly 7 -> 8, single upd, no wrap.
REQ-032 value=15, then cnt_in=0 held -> upd and wrap pulse in the same cycle, wrap_count 0 -> 1.
REQ-033 Drive 256 full 0..15 cycles -> wrap_count returns to 0, 256 wrap pulses.
REQ-034 cnt_in toggles 3/4 every 2 cycles with STABLE_CYCLES=3 -> value unchanged, no upd.
REQ-035 Assert rst at stab=2 while qualifying 9 -> outputs 0, no pulses; build without COUNT_CAPTURE_SEG7_EN -> same results, no seg port.
